secuenciador_mac: RTL and testbench

Control FSM for the time-multiplexed FIR datapath: accepts one input sample per handshake, drives the delay-line write, the accumulator clear, the MAC enable and the coefficient/tap address, and flags the finished output sample. It sits upstream of the MAC/accumulator datapath and downstream of the sample source (ADC interface or decimator). It owns all sequencing of one filter output, so the datapath has no control logic of its own.

---
 rtl/secuenciador_mac_pkg.sv | 28 ++
 rtl/secuenciador_mac_contador_indice.sv | 30 +++
 rtl/secuenciador_mac.sv | 114 +++++++++++
 tb/tb_secuenciador_mac.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_mac_pkg.sv
// rtl/secuenciador_mac_pkg.sv - state encoding and parameter width check for secuenciador_mac
`ifndef SECUENCIADOR_MAC_PKG_SV
`define SECUENCIADOR_MAC_PKG_SV

`define SECUENCIADOR_CHECK_ANCHO(bits, n) \
  if ((1 << (bits)) < (n)) begin : g_ancho_invalido \
    $error("BITS_DIRECCION too narrow for N_TAPS"); \
  end

package secuenciador_mac_pkg;

  localparam logic [2:0] ST_REPOSO  = 3'd0;
  localparam logic [2:0] ST_CARGA   = 3'd1;
  localparam logic [2:0] ST_ACUMULA = 3'd2;
  localparam logic [2:0] ST_DRENAJE = 3'd3;
  localparam logic [2:0] ST_ENTREGA = 3'd4;

  typedef enum logic [2:0] {
    REPOSO  = ST_REPOSO,
    CARGA   = ST_CARGA,
    ACUMULA = ST_ACUMULA,
    DRENAJE = ST_DRENAJE,
    ENTREGA = ST_ENTREGA
  } estado_t;

endpackage

`endif

// File: rtl/secuenciador_mac_contador_indice.sv
// rtl/secuenciador_mac_contador_indice.sv - saturating up-counter with clear, enable and terminal count
module contador_indice #(
  parameter int ANCHO  = 4,
  parameter int LIMITE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_limpiar,
  input  logic             i_habilitar,
  output logic [ANCHO-1:0] o_cuenta,
  output logic             o_terminal
);

  localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(LIMITE - 1);

  logic [ANCHO-1:0] r_cuenta;

  // Holds at LIMITE-1 so the index can never wrap past the last tap.
  always_ff @(posedge clk) begin
    if (reset || i_limpiar) begin
      r_cuenta <= '0;
    end else if (i_habilitar && (r_cuenta != ULTIMO)) begin
      r_cuenta <= r_cuenta + 1'b1;
    end
  end

  assign o_cuenta   = r_cuenta;
  assign o_terminal = (r_cuenta == ULTIMO);

endmodule

// File: rtl/secuenciador_mac.sv
// rtl/secuenciador_mac.sv - control FSM sequencing one output of a time-multiplexed FIR MAC datapath
module secuenciador_mac
  import secuenciador_mac_pkg::*;
#(
  parameter int N_TAPS         = 16,
  parameter int BITS_DIRECCION = 4,
  parameter int LATENCIA_MAC   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      muestra_valida,
  output logic                      listo_para_muestra,
  output logic                      escribir_muestra,
  output logic                      limpiar_acumulador,
  output logic                      habilitar_mac,
  output logic [BITS_DIRECCION-1:0] direccion_coef,
  output logic                      salida_valida,
  output logic                      muestra_perdida
);

  localparam int ANCHO_DRENAJE = (LATENCIA_MAC > 1) ? $clog2(LATENCIA_MAC) : 1;

  `SECUENCIADOR_CHECK_ANCHO(BITS_DIRECCION, N_TAPS)

  estado_t                   r_estado;
  estado_t                   w_siguiente;
  logic                      r_perdida;
  logic                      w_arranque;
  logic                      w_indice_fin;
  logic                      w_drenaje_fin;
  logic [BITS_DIRECCION-1:0] w_indice;

  assign w_arranque = (r_estado == REPOSO) && muestra_valida;

  contador_indice #(
    .ANCHO  (BITS_DIRECCION),
    .LIMITE (N_TAPS)
  ) u_indice (
    .clk         (clk),
    .reset       (reset),
    .i_limpiar   (w_arranque),
    .i_habilitar (r_estado == ACUMULA),
    .o_cuenta    (w_indice),
    .o_terminal  (w_indice_fin)
  );

  generate
    if (LATENCIA_MAC > 0) begin : g_drenaje
      logic [ANCHO_DRENAJE-1:0] w_unused_cuenta_drenaje;
      contador_indice #(
        .ANCHO  (ANCHO_DRENAJE),
        .LIMITE (LATENCIA_MAC)
      ) u_drenaje (
        .clk         (clk),
        .reset       (reset),
        .i_limpiar   (w_arranque),
        .i_habilitar (r_estado == DRENAJE),
        .o_cuenta    (w_unused_cuenta_drenaje),
        .o_terminal  (w_drenaje_fin)
      );
    end else begin : g_sin_drenaje
      assign w_drenaje_fin = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= REPOSO;
      r_perdida <= 1'b0;
    end else begin
      r_estado <= w_siguiente;
      if (muestra_valida && (r_estado != REPOSO)) begin
        r_perdida <= 1'b1;
      end
    end
  end

  always_comb begin
    w_siguiente        = r_estado;
    listo_para_muestra = 1'b0;
    escribir_muestra   = 1'b0;
    limpiar_acumulador = 1'b0;
    habilitar_mac      = 1'b0;
    direccion_coef     = '0;
    salida_valida      = 1'b0;
    case (r_estado)
      REPOSO: begin
        listo_para_muestra = 1'b1;
        if (muestra_valida) w_siguiente = CARGA;
      end
      CARGA: begin
        escribir_muestra   = 1'b1;
        limpiar_acumulador = 1'b1;
        w_siguiente        = ACUMULA;
      end
      ACUMULA: begin
        habilitar_mac  = 1'b1;
        direccion_coef = w_indice;
        if (w_indice_fin) w_siguiente = (LATENCIA_MAC == 0) ? ENTREGA : DRENAJE;
      end
      DRENAJE: begin
        if (w_drenaje_fin) w_siguiente = ENTREGA;
      end
      ENTREGA: begin
        salida_valida = 1'b1;
        w_siguiente   = REPOSO;
      end
      default: w_siguiente = REPOSO;
    endcase
  end

  assign muestra_perdida = r_perdida;

endmodule

// File: tb/tb_secuenciador_mac.sv
// tb/tb_secuenciador_mac.sv - randomized scoreboard bench for secuenciador_mac
module tb_secuenciador_mac;

  localparam int N   = 16;
  localparam int L   = 2;
  localparam int BIG = 1 << 30;

  logic       clk;
  logic       reset;
  logic       muestra_valida;
  logic       listo;
  logic       esc;
  logic       lim;
  logic       mac;
  logic [3:0] dir;
  logic       salida;
  logic       perdida;

  logic       reset1;
  logic       mv1;
  logic       listo1;
  logic       esc1;
  logic       lim1;
  logic       mac1;
  logic [0:0] dir1;
  logic       salida1;
  logic       perdida1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_from = BIG;
  int s_start = -1000;
  int s_cut = BIG;
  int ready_at = 0;
  int lost_from = BIG;
  int lost_until = BIG;
  int q[$];
  logic [7:0] act_v;
  logic [7:0] exp_v;
  logic       exp_p;
  int         e_cyc;

  secuenciador_mac dut (
    .clk                (clk),
    .reset              (reset),
    .muestra_valida     (muestra_valida),
    .listo_para_muestra (listo),
    .escribir_muestra   (esc),
    .limpiar_acumulador (lim),
    .habilitar_mac      (mac),
    .direccion_coef     (dir),
    .salida_valida      (salida),
    .muestra_perdida    (perdida)
  );

  secuenciador_mac #(
    .N_TAPS         (1),
    .BITS_DIRECCION (1),
    .LATENCIA_MAC   (0)
  ) dut1 (
    .clk                (clk),
    .reset              (reset1),
    .muestra_valida     (mv1),
    .listo_para_muestra (listo1),
    .escribir_muestra   (esc1),
    .limpiar_acumulador (lim1),
    .habilitar_mac      (mac1),
    .direccion_coef     (dir1),
    .salida_valida      (salida1),
    .muestra_perdida    (perdida1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Expected {listo, escribir, limpiar, mac, direccion} from the offset within the sample's timeline.
  function automatic logic [7:0] esperado(input int c);
    int         k;
    logic [7:0] v;
    k = c - s_start;
    v = 8'b1000_0000;
    if ((c < s_cut) && (k >= 1) && (k <= N + 2 + L)) begin
      v = 8'b0;
      if (k == 1) v[6:5] = 2'b11;
      else if (k <= N + 1) begin
        v[4]   = 1'b1;
        v[3:0] = 4'(k - 2);
      end
    end
    return v;
  endfunction

  task automatic drive(input logic v, input logic r);
    @(posedge clk);
    #1;
    cyc++;
    muestra_valida = v;
    reset = r;
    if (r) begin
      s_cut = cyc + 1;
      ready_at = cyc + 1;
      if (lost_until > cyc) lost_until = cyc;
      while ((q.size() > 0) && (q[$] > cyc)) void'(q.pop_back());
    end else if (v) begin
      if (cyc >= ready_at) begin
        s_start = cyc;
        s_cut = BIG;
        q.push_back(cyc + N + 2 + L);
        ready_at = cyc + N + 3 + L;
      end else if (!((lost_from <= cyc + 1) && (cyc + 1 <= lost_until))) begin
        lost_from = cyc + 1;
        lost_until = BIG;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (cyc >= mon_from) begin
      act_v = {listo, esc, lim, mac, dir};
      exp_v = esperado(cyc);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL strobes cycle %0d: got %b required %b", cyc, act_v, exp_v);
      end
      exp_p = (lost_from <= cyc) && (cyc <= lost_until);
      checks++;
      if (perdida !== exp_p) begin
        errors++;
        $display("FAIL muestra_perdida cycle %0d: got %b required %b", cyc, perdida, exp_p);
      end
      if ((q.size() > 0) && (q[0] < cyc)) begin
        checks++;
        errors++;
        $display("FAIL salida_missing: got none required cycle %0d", q[0]);
        void'(q.pop_front());
      end
      if (salida !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL salida_unexpected: got pulse at cycle %0d required none", cyc);
        end else begin
          e_cyc = q.pop_front();
          if (e_cyc != cyc) begin
            errors++;
            $display("FAIL salida_cycle: got %0d required %0d", cyc, e_cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0] a1;
    logic [5:0] e1;
    reset = 1'b1;
    reset1 = 1'b1;
    muestra_valida = 1'b0;
    mv1 = 1'b0;

    // Single-tap, zero-latency instance: pulse in cycle 0, result in cycle 3.
    repeat (3) @(posedge clk);
    #1;
    reset1 = 1'b0;
    mv1 = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      a1 = {listo1, esc1, lim1, mac1, dir1, salida1};
      e1 = {(k == 0 || k >= 4), (k == 1), (k == 1), (k == 2), 1'b0, (k == 3)};
      checks++;
      if ((a1 !== e1) || (perdida1 !== 1'b0)) begin
        errors++;
        $display("FAIL ntaps1 cycle %0d: got %b/%b required %b/0", k, a1, perdida1, e1);
      end
      @(posedge clk);
      #1;
      mv1 = 1'b0;
    end

    drive(1'b0, 1'b1);
    mon_from = cyc + 1;
    drive(1'b0, 1'b1);
    idle(5);

    drive(1'b1, 1'b0);
    idle(25);

    drive(1'b1, 1'b0);
    idle(9);
    drive(1'b1, 1'b0);
    idle(20);
    drive(1'b0, 1'b1);

    drive(1'b1, 1'b0);
    idle(20);
    drive(1'b1, 1'b0);
    idle(25);

    drive(1'b1, 1'b0);
    idle(7);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    idle(25);

    drive(1'b1, 1'b1);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end
    idle(30);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
